// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage assembling 16/32-bit instructions; HLT stop when FETCH_HALT_EN is defined
module fetch_unit #(
  parameter int                       WORD_LENGTH   = 16,
  parameter int                       ADDRESS_SPACE = 21,
  parameter logic [ADDRESS_SPACE-1:0] RESET_PC      = '0,
  parameter logic [4:0]               HALT_OPCODE   = 5'b11111
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [ADDRESS_SPACE-1:0] mem_addr,
  input  logic [WORD_LENGTH-1:0]   mem_data,
  input  logic                     stall,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_SPACE-1:0] redirect_pc,
  output logic                     instr_valid,
  output logic [WORD_LENGTH-1:0]   instr_hi,
  output logic [WORD_LENGTH-1:0]   instr_lo,
  output logic                     instr_is_long,
  output logic [ADDRESS_SPACE-1:0] instr_pc,
  output logic                     halted
);

  typedef enum logic {
    ST_HI,
    ST_LO
  } state_t;

  state_t                   state, state_n;
  logic [ADDRESS_SPACE-1:0] pc, pc_n;
  logic                     resp_valid, resp_valid_n;
  logic [ADDRESS_SPACE-1:0] resp_pc, resp_pc_n;
  logic [WORD_LENGTH-1:0]   hi_buf, hi_buf_n;
  logic [ADDRESS_SPACE-1:0] hold_pc, hold_pc_n;

  logic                     instr_valid_n;
  logic [WORD_LENGTH-1:0]   instr_hi_n;
  logic [WORD_LENGTH-1:0]   instr_lo_n;
  logic                     instr_is_long_n;
  logic [ADDRESS_SPACE-1:0] instr_pc_n;
  logic                     halted_n;

  assign mem_addr = pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_HI;
      pc            <= RESET_PC;
      resp_valid    <= 1'b0;
      resp_pc       <= '0;
      hi_buf        <= '0;
      hold_pc       <= '0;
      instr_valid   <= 1'b0;
      instr_hi      <= '0;
      instr_lo      <= '0;
      instr_is_long <= 1'b0;
      instr_pc      <= '0;
    end else begin
      state         <= state_n;
      pc            <= pc_n;
      resp_valid    <= resp_valid_n;
      resp_pc       <= resp_pc_n;
      hi_buf        <= hi_buf_n;
      hold_pc       <= hold_pc_n;
      instr_valid   <= instr_valid_n;
      instr_hi      <= instr_hi_n;
      instr_lo      <= instr_lo_n;
      instr_is_long <= instr_is_long_n;
      instr_pc      <= instr_pc_n;
    end
  end

`ifdef FETCH_HALT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      halted <= 1'b0;
    end else begin
      halted <= halted_n;
    end
  end
`else
  assign halted = 1'b0;
`endif

  always_comb begin
    state_n         = state;
    pc_n            = pc;
    resp_valid_n    = resp_valid;
    resp_pc_n       = resp_pc;
    hi_buf_n        = hi_buf;
    hold_pc_n       = hold_pc;
    instr_valid_n   = instr_valid;
    instr_hi_n      = instr_hi;
    instr_lo_n      = instr_lo;
    instr_is_long_n = instr_is_long;
    instr_pc_n      = instr_pc;
    halted_n        = halted;

    if (redirect_valid) begin
      pc_n          = redirect_pc;
      resp_valid_n  = 1'b0;
      state_n       = ST_HI;
      hi_buf_n      = '0;
      instr_valid_n = 1'b0;
      halted_n      = 1'b0;
    end else if (stall) begin
      // The response arriving this cycle cannot be consumed, so refetch its address.
      pc_n         = resp_valid ? resp_pc : pc;
      resp_valid_n = 1'b0;
`ifdef FETCH_HALT_EN
    end else if (halted) begin
      resp_valid_n  = 1'b0;
      instr_valid_n = 1'b0;
`endif
    end else begin
      pc_n          = pc + 1'b1;
      resp_valid_n  = 1'b1;
      resp_pc_n     = pc;
      instr_valid_n = 1'b0;
      if (resp_valid) begin
        case (state)
          ST_HI: begin
            if (!mem_data[0]) begin
              instr_valid_n   = 1'b1;
              instr_hi_n      = mem_data;
              instr_lo_n      = '0;
              instr_is_long_n = 1'b0;
              instr_pc_n      = resp_pc;
`ifdef FETCH_HALT_EN
              if (mem_data[WORD_LENGTH-1 -: 5] == HALT_OPCODE) begin
                halted_n     = 1'b1;
                pc_n         = pc;
                resp_valid_n = 1'b0;
              end
`endif
            end else begin
              hi_buf_n  = mem_data;
              hold_pc_n = resp_pc;
              state_n   = ST_LO;
            end
          end
          ST_LO: begin
            instr_valid_n   = 1'b1;
            instr_hi_n      = hi_buf;
            instr_lo_n      = mem_data;
            instr_is_long_n = 1'b1;
            instr_pc_n      = hold_pc;
            state_n         = ST_HI;
          end
          default: state_n = ST_HI;
        endcase
      end
    end
  end

endmodule
